// File: rtl/bit_shift_engine.sv
// bit_shift_engine: button-driven WIDTH-bit LED pattern with saturate/rotate
// shifting, restore, invert and hold-to-repeat auto-shifting.
//
// Handshake note: there is no valid/ready traffic here. Buttons are raw
// asynchronous levels. Every output is a registered level, except at_left and
// at_right, which are direct taps of the registered pattern. shift_pulse is a
// one-cycle strobe aligned with the edge that changed bits.
module bit_shift_engine #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] START_BITS    = 8'b00011000,
  parameter int               BUTTON_COUNT  = 24,
  parameter int               SYNC_STAGES   = 2,
  parameter int               REPEAT_DELAY  = 20,
  parameter int               REPEAT_PERIOD = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BUTTON_COUNT-1:0] buttons,
  output logic [WIDTH-1:0]        bits,
  output logic                    wrap_mode,
  output logic                    at_left,
  output logic                    at_right,
  output logic                    shift_pulse
);

  // Button bit positions inside the 5-bit working vector.
  localparam int BTN_RIGHT   = 0;
  localparam int BTN_LEFT    = 1;
  localparam int BTN_RESTORE = 2;
  localparam int BTN_INVERT  = 3;
  localparam int BTN_WRAP    = 4;

  // Repeat FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // The counter is shared by DELAY and REPEAT. It must reach the larger of the
  // two terminal values.
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  // Buttons above index 4 carry no function. They are folded into a sink so
  // that the intent is explicit.
  generate
    if (BUTTON_COUNT > 5) begin : g_unused_buttons
      logic unused_buttons;
      assign unused_buttons = ^buttons[BUTTON_COUNT-1:5];
    end
  endgenerate

  logic [4:0]       sync_q [SYNC_STAGES];
  logic [4:0]       btn_s;
  logic [4:0]       btn_p;
  logic [4:0]       press;

  logic [WIDTH-1:0] bits_q;
  logic [WIDTH-1:0] bits_d;
  logic             wrap_q;
  logic             pulse_q;
  logic             pulse_d;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             dir_q;     // 0 = right, 1 = left
  logic             dir_d;
  logic             fsm_shift;
  logic             dir_held;
  logic             both_held;

  logic [WIDTH-1:0] shift_right_val;
  logic [WIDTH-1:0] shift_left_val;
  logic [WIDTH-1:0] shift_val;

  // Internal probe of the repeat FSM state, available for checkers to bind to.
  logic [1:0]       dbg_state;
  assign dbg_state = state_q;

  // Synchroniser chain: each button passes through SYNC_STAGES flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= buttons[4:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Previous-sample register used for rising-edge (press) detection.
  always_ff @(posedge clk) begin
    if (!rst_n) btn_p <= '0;
    else        btn_p <= btn_s;
  end

  assign press     = btn_s & ~btn_p;
  assign dir_held  = dir_q ? btn_s[BTN_LEFT] : btn_s[BTN_RIGHT];
  assign both_held = btn_s[BTN_LEFT] & btn_s[BTN_RIGHT];

  // Repeat FSM next-state logic.
  // It decides whether a shift is requested this cycle, and in which direction.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    fsm_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press[BTN_RIGHT] && !btn_s[BTN_LEFT]) begin
          fsm_shift = 1'b1;
          dir_d     = 1'b0;
          if (REPEAT_DELAY > 0) begin
            state_d = ST_DELAY;
            cnt_d   = '0;
          end
        end else if (press[BTN_LEFT] && !btn_s[BTN_RIGHT]) begin
          fsm_shift = 1'b1;
          dir_d     = 1'b1;
          if (REPEAT_DELAY > 0) begin
            state_d = ST_DELAY;
            cnt_d   = '0;
          end
        end
      end
      ST_DELAY: begin
        if (!dir_held || both_held) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DELAY_LAST) begin
          fsm_shift = 1'b1;
          state_d   = ST_REPEAT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!dir_held || both_held) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PERIOD_LAST) begin
          fsm_shift = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Repeat FSM state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Candidate shifted patterns.
  // In saturate mode a set edge bit blocks the shift. An all-zero pattern maps
  // to itself in both modes, so it can never count as a change.
  always_comb begin
    if (wrap_q) begin
      shift_right_val = {bits_q[0], bits_q[WIDTH-1:1]};
      shift_left_val  = {bits_q[WIDTH-2:0], bits_q[WIDTH-1]};
    end else begin
      shift_right_val = bits_q[0]       ? bits_q : (bits_q >> 1);
      shift_left_val  = bits_q[WIDTH-1] ? bits_q : (bits_q << 1);
    end
    shift_val = dir_d ? shift_left_val : shift_right_val;
  end

  // Pattern update with priority restore > invert > shift.
  // A lower-priority event in the same cycle is simply dropped.
  always_comb begin
    bits_d  = bits_q;
    pulse_d = 1'b0;
    if (press[BTN_RESTORE]) begin
      bits_d = START_BITS;
    end else if (press[BTN_INVERT]) begin
      bits_d = ~bits_q;
    end else if (fsm_shift) begin
      bits_d  = shift_val;
      pulse_d = (shift_val != bits_q);
    end
  end

  // Pattern, mode and strobe registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits_q  <= START_BITS;
      wrap_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      wrap_q  <= wrap_q ^ press[BTN_WRAP];
      pulse_q <= pulse_d;
    end
  end

  assign bits        = bits_q;
  assign wrap_mode   = wrap_q;
  assign at_left     = bits_q[WIDTH-1];
  assign at_right    = bits_q[0];
  assign shift_pulse = pulse_q;

endmodule

// File: tb/tb_bit_shift_engine.sv
// Directed testbench for bit_shift_engine.
// Instance A is 8 bits wide with auto-repeat disabled.
// Instance B is 16 bits wide with REPEAT_DELAY=20 and REPEAT_PERIOD=5.
module tb_bit_shift_engine;

  logic        clk;
  logic        rst_n;
  logic [23:0] buttons_a;
  logic [23:0] buttons_b;

  logic [7:0]  bits_a;
  logic        wrap_a, left_a, right_a, pulse_a;
  logic [15:0] bits_b;
  logic        wrap_b, left_b, right_b, pulse_b;

  int          n_tests;
  int          n_fail;
  int          cycle;
  int          pulse_cnt_a;
  int          pulse_cnt_b;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  bit_shift_engine #(
    .WIDTH(8), .START_BITS(8'b00011000), .BUTTON_COUNT(24),
    .SYNC_STAGES(2), .REPEAT_DELAY(0), .REPEAT_PERIOD(5)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .buttons(buttons_a), .bits(bits_a),
    .wrap_mode(wrap_a), .at_left(left_a), .at_right(right_a),
    .shift_pulse(pulse_a)
  );

  bit_shift_engine #(
    .WIDTH(16), .START_BITS(16'h0001), .BUTTON_COUNT(24),
    .SYNC_STAGES(2), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .buttons(buttons_b), .bits(bits_b),
    .wrap_mode(wrap_b), .at_left(left_b), .at_right(right_b),
    .shift_pulse(pulse_b)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (pulse_a) pulse_cnt_a++;
    if (pulse_b) begin
      pulse_cnt_b++;
      got_q.push_back(32'(cycle));
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold the masked buttons for 4 cycles, then release them for 4 cycles.
  task automatic press_a(input logic [4:0] mask);
    buttons_a[4:0] = mask;
    repeat (4) tick();
    buttons_a[4:0] = '0;
    repeat (4) tick();
  endtask

  task automatic press_b(input logic [4:0] mask);
    buttons_b[4:0] = mask;
    repeat (4) tick();
    buttons_b[4:0] = '0;
    repeat (4) tick();
  endtask

  initial begin
    int start;
    logic [31:0] got;
    n_tests = 0; n_fail = 0; cycle = 0;
    pulse_cnt_a = 0; pulse_cnt_b = 0;
    rst_n = 1'b0;
    buttons_a = '0;
    buttons_b = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_bits_a",  32'(bits_a), 32'h18);
    check("rst_wrap_a",  32'(wrap_a), 32'd0);
    check("rst_left_a",  32'(left_a), 32'd0);
    check("rst_right_a", 32'(right_a), 32'd0);
    check("rst_pulse_a", 32'(pulse_a), 32'd0);
    check("rst_bits_b",  32'(bits_b), 32'h0001);
    rst_n = 1'b1;
    repeat (2) tick();

    // Ten right presses in saturate mode: three real shifts, then blocked.
    pulse_cnt_a = 0;
    for (int i = 0; i < 10; i++) press_a(5'b00001);
    check("sat_right_bits",  32'(bits_a), 32'h03);
    check("sat_right_edge",  32'(right_a), 32'd1);
    check("sat_right_count", 32'(pulse_cnt_a), 32'd3);

    // Ten left presses: six shifts up to 11000000.
    pulse_cnt_a = 0;
    for (int i = 0; i < 10; i++) press_a(5'b00010);
    check("sat_left_bits",  32'(bits_a), 32'hC0);
    check("sat_left_edge",  32'(left_a), 32'd1);
    check("sat_left_count", 32'(pulse_cnt_a), 32'd6);
    pulse_cnt_a = 0;
    press_a(5'b00010);
    check("sat_left_blocked",       32'(bits_a), 32'hC0);
    check("sat_left_blocked_pulse", 32'(pulse_cnt_a), 32'd0);

    // Switch to rotate mode, then rotate left twice.
    press_a(5'b10000);
    check("wrap_on_a", 32'(wrap_a), 32'd1);
    press_a(5'b00010);
    check("rot_left_1", 32'(bits_a), 32'h81);
    press_a(5'b00010);
    check("rot_left_2", 32'(bits_a), 32'h03);

    // Hold-to-repeat on B: rotate mode, then hold left for 50 cycles.
    press_b(5'b10000);
    check("wrap_on_b", 32'(wrap_b), 32'd1);
    got_q.delete();
    pulse_cnt_b = 0;
    start = cycle;
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(32'(start + 3));
    exp_q.push_back(32'(start + 23));
    exp_q.push_back(32'(start + 28));
    exp_q.push_back(32'(start + 33));
    exp_q.push_back(32'(start + 38));
    exp_q.push_back(32'(start + 43));
    exp_q.push_back(32'(start + 48));
    buttons_b[1] = 1'b1;
    repeat (50) tick();
    check("hold_bits_b", 32'(bits_b), 32'h0080);
    buttons_b[1] = 1'b0;
    repeat (20) tick();
    check("release_bits_b",  32'(bits_b), 32'h0080);
    check("hold_pulse_count", 32'(pulse_cnt_b), 32'd7);
    while (exp_q.size() > 0) begin
      got = (got_q.size() > 0) ? got_q.pop_front() : 32'hFFFF_FFFF;
      check("repeat_time", got - 32'(start), exp_q.pop_front() - 32'(start));
    end

    // Restore, invert and right pressed together: restore wins, no shift.
    pulse_cnt_a = 0;
    press_a(5'b01101);
    check("prio_bits",  32'(bits_a), 32'h18);
    check("prio_pulse", 32'(pulse_cnt_a), 32'd0);

    // Invert alone.
    press_a(5'b01000);
    check("invert_bits",  32'(bits_a), 32'hE7);
    check("invert_pulse", 32'(pulse_cnt_a), 32'd0);

    // Reset while right is held: the hold survives reset and becomes a fresh edge.
    buttons_a[0] = 1'b1;
    repeat (4) tick();
    check("hold_rot_right", 32'(bits_a), 32'hF3);
    rst_n = 1'b0;
    tick();
    check("midhold_rst_bits", 32'(bits_a), 32'h18);
    check("midhold_rst_wrap", 32'(wrap_a), 32'd0);
    tick();
    rst_n = 1'b1;
    pulse_cnt_a = 0;
    repeat (2) tick();
    check("post_rst_wait", 32'(bits_a), 32'h18);
    tick();
    check("post_rst_shift", 32'(bits_a), 32'h0C);
    check("post_rst_pulse", 32'(pulse_a), 32'd1);
    buttons_a[0] = 1'b0;
    repeat (6) tick();
    check("post_rst_single", 32'(pulse_cnt_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
